// File: rtl/ahblite_timer.sv
`default_nettype none
// ============================================================================
// Module   : ahblite_timer
// Brief    : AHB-Lite zero-wait-state prescaled down-counting timer with
//            auto-reload / one-shot modes and a sticky level interrupt.
// Revision : 1.0 - initial release
// ============================================================================

module ahblite_timer #(
    parameter int CNT_W   = 32,
    parameter int PRESC_W = 16
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic [2:0]  HSIZE,
    input  logic [3:0]  HPROT,
    input  logic        HWRITE,
    input  logic [31:0] HWDATA,
    input  logic        HREADY,
    output logic        HREADYOUT,
    output logic [31:0] HRDATA,
    output logic        HRESP,
    output logic        IRQ
);

    localparam logic [2:0] c_ADDR_CTRL   = 3'd0;
    localparam logic [2:0] c_ADDR_LOAD   = 3'd1;
    localparam logic [2:0] c_ADDR_VALUE  = 3'd2;
    localparam logic [2:0] c_ADDR_PRESC  = 3'd3;
    localparam logic [2:0] c_ADDR_STATUS = 3'd4;

    logic               r_wr_pend_q, w_wr_pend_d;
    logic               r_rd_pend_q, w_rd_pend_d;
    logic [2:0]         r_addr_q,    w_addr_d;
    logic               r_en_q,      w_en_d;
    logic               r_ie_q,      w_ie_d;
    logic               r_oneshot_q, w_oneshot_d;
    logic               r_tif_q,     w_tif_d;
    logic [CNT_W-1:0]   r_load_q,    w_load_d;
    logic [CNT_W-1:0]   r_value_q,   w_value_d;
    logic [PRESC_W-1:0] r_presc_q,   w_presc_d;
    logic [PRESC_W-1:0] r_pcnt_q,    w_pcnt_d;

    logic w_aphase;
    logic w_tick;
    logic w_expire;
    logic w_wr_ctrl, w_wr_load, w_wr_value, w_wr_presc, w_wr_status;

    // Size/protection and the non-decoded address bits carry no meaning here.
    logic w_unused;
    assign w_unused = ^{HSIZE, HPROT, HADDR[31:5], HADDR[1:0], HTRANS[0], HWDATA};

    assign HREADYOUT = 1'b1;
    assign HRESP     = 1'b0;
    assign IRQ       = r_tif_q & r_ie_q;

    always_comb begin
        w_aphase    = HSEL && HREADY && HTRANS[1];
        w_wr_pend_d = w_aphase && HWRITE;
        w_rd_pend_d = w_aphase && !HWRITE;
        w_addr_d    = w_aphase ? HADDR[4:2] : r_addr_q;

        w_wr_ctrl   = r_wr_pend_q && (r_addr_q == c_ADDR_CTRL);
        w_wr_load   = r_wr_pend_q && (r_addr_q == c_ADDR_LOAD);
        w_wr_value  = r_wr_pend_q && (r_addr_q == c_ADDR_VALUE);
        w_wr_presc  = r_wr_pend_q && (r_addr_q == c_ADDR_PRESC);
        w_wr_status = r_wr_pend_q && (r_addr_q == c_ADDR_STATUS);

        w_tick   = r_en_q && (r_pcnt_q == r_presc_q);
        w_expire = w_tick && (r_value_q == '0);

        w_en_d      = r_en_q;
        w_ie_d      = r_ie_q;
        w_oneshot_d = r_oneshot_q;
        if (w_expire && r_oneshot_q) begin
            w_en_d = 1'b0;
        end
        if (w_wr_ctrl) begin
            w_en_d      = HWDATA[0];
            w_ie_d      = HWDATA[1];
            w_oneshot_d = HWDATA[2];
        end

        w_load_d  = w_wr_load  ? HWDATA[CNT_W-1:0]   : r_load_q;
        w_presc_d = w_wr_presc ? HWDATA[PRESC_W-1:0] : r_presc_q;

        w_value_d = r_value_q;
        if (w_tick) begin
            w_value_d = w_expire ? r_load_q : (r_value_q - CNT_W'(1));
        end
        if (w_wr_value) begin
            w_value_d = HWDATA[CNT_W-1:0];
        end

        // A set from an expiry outranks a same-cycle write-one-to-clear.
        w_tif_d = r_tif_q;
        if (w_wr_status && HWDATA[0]) begin
            w_tif_d = 1'b0;
        end
        if (w_expire) begin
            w_tif_d = 1'b1;
        end

        // Parking pcnt at 0 whenever the timer stops makes every enable start a full prescale period.
        if (!r_en_q || !w_en_d || w_tick) begin
            w_pcnt_d = '0;
        end else begin
            w_pcnt_d = r_pcnt_q + PRESC_W'(1);
        end
    end

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            r_wr_pend_q <= 1'b0;
            r_rd_pend_q <= 1'b0;
            r_addr_q    <= '0;
            r_en_q      <= 1'b0;
            r_ie_q      <= 1'b0;
            r_oneshot_q <= 1'b0;
            r_tif_q     <= 1'b0;
            r_load_q    <= '0;
            r_value_q   <= '0;
            r_presc_q   <= '0;
            r_pcnt_q    <= '0;
        end else begin
            r_wr_pend_q <= w_wr_pend_d;
            r_rd_pend_q <= w_rd_pend_d;
            r_addr_q    <= w_addr_d;
            r_en_q      <= w_en_d;
            r_ie_q      <= w_ie_d;
            r_oneshot_q <= w_oneshot_d;
            r_tif_q     <= w_tif_d;
            r_load_q    <= w_load_d;
            r_value_q   <= w_value_d;
            r_presc_q   <= w_presc_d;
            r_pcnt_q    <= w_pcnt_d;
        end
    end

    always_comb begin
        HRDATA = '0;
        if (r_rd_pend_q) begin
            case (r_addr_q)
                c_ADDR_CTRL:   HRDATA[2:0]         = {r_oneshot_q, r_ie_q, r_en_q};
                c_ADDR_LOAD:   HRDATA[CNT_W-1:0]   = r_load_q;
                c_ADDR_VALUE:  HRDATA[CNT_W-1:0]   = r_value_q;
                c_ADDR_PRESC:  HRDATA[PRESC_W-1:0] = r_presc_q;
                c_ADDR_STATUS: HRDATA[0]           = r_tif_q;
                default:       HRDATA              = '0;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_ahblite_timer.sv
`default_nettype none
// ============================================================================
// Module   : tb_ahblite_timer
// Brief    : Self-checking bench for ahblite_timer against a closed-form timer model.
// Revision : 1.0 - initial release
// ============================================================================

module tb_ahblite_timer;

    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic        HSEL;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic [2:0]  HSIZE;
    logic [3:0]  HPROT;
    logic        HWRITE;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic        HREADYOUT;
    logic [31:0] HRDATA;
    logic        HRESP;
    logic        IRQ;

    ahblite_timer #(.CNT_W(32), .PRESC_W(16)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR),
        .HTRANS(HTRANS), .HSIZE(HSIZE), .HPROT(HPROT), .HWRITE(HWRITE),
        .HWDATA(HWDATA), .HREADY(HREADY), .HREADYOUT(HREADYOUT),
        .HRDATA(HRDATA), .HRESP(HRESP), .IRQ(IRQ)
    );

    always #5 HCLK = ~HCLK;

    int cyc = 0;
    always @(posedge HCLK) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    // Reference timer: state after edge c follows from the enable edge m_e by arithmetic.
    int m_e = 0, m_v0 = 0, m_load = 0, m_p = 0, m_clr = 0;
    bit m_en = 0, m_os = 0, m_ie = 0, m_tif_base = 0;

    function automatic int ticks(int c);
        if (!m_en || c <= m_e) return 0;
        return (c - m_e) / (m_p + 1);
    endfunction

    function automatic int value_at(int c);
        int n;
        n = ticks(c);
        if (n <= m_v0) return m_v0 - n;
        if (m_os) return m_load;
        return m_load - ((n - m_v0 - 1) % (m_load + 1));
    endfunction

    function automatic bit en_at(int c);
        return m_en && !(m_os && ticks(c) >= m_v0 + 1);
    endfunction

    function automatic bit expiry_in(int lo, int hi);
        int t, x;
        bit r, done;
        r = 0; done = !m_en; t = m_v0 + 1;
        while (!done) begin
            x = m_e + (m_p + 1) * t;
            if (x > hi) done = 1;
            else if (x >= lo) begin r = 1; done = 1; end
            else if (m_os) done = 1;
            else t += m_load + 1;
        end
        return r;
    endfunction

    function automatic bit tif_at(int c);
        return m_tif_base || expiry_in((m_clr > m_e) ? m_clr : m_e + 1, c);
    endfunction

    function automatic logic [31:0] exp_reg(logic [31:0] a, int c);
        case (a[4:2])
            3'd0:    return {29'b0, m_os, m_ie, en_at(c)};
            3'd1:    return 32'(m_load);
            3'd2:    return 32'(value_at(c));
            3'd3:    return 32'(m_p);
            3'd4:    return {31'b0, tif_at(c)};
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_clear(input int c);
        m_tif_base = 0;
        m_clr      = c;
    endtask

    // A VALUE write landing on a tick edge restarts the arithmetic from that edge.
    task automatic model_value_write(input int c, input int w);
        m_tif_base = tif_at(c);
        m_clr      = c;
        m_e        = c;
        m_v0       = w;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic bus_write_at(input logic [31:0] a, input logic [31:0] d, input int target,
                                output int land);
        @(posedge HCLK); #1;
        while (cyc < target - 2) begin
            @(posedge HCLK); #1;
        end
        HSEL = 1; HTRANS = 2'b10; HWRITE = 1; HADDR = a;
        @(posedge HCLK); #1;
        HSEL = 0; HTRANS = 2'b00; HWRITE = 0; HWDATA = d;
        land = cyc + 1;
    endtask

    task automatic rd_chk(input logic [31:0] a, input string tag);
        int smp;
        @(posedge HCLK); #1;
        HSEL = 1; HTRANS = 2'b10; HWRITE = 0; HADDR = a;
        @(posedge HCLK); #1;
        HSEL = 0; HTRANS = 2'b00;
        smp = cyc;
        @(negedge HCLK);
        check(tag, HRDATA, exp_reg(a, smp));
        check({tag, "_irq"}, {31'b0, IRQ}, {31'b0, tif_at(smp) && m_ie});
        check({tag, "_okay"}, {30'b0, HREADYOUT, HRESP}, 32'h2);
    endtask

    task automatic setup(input int l, input int p, input int v0, input logic [2:0] ctrl);
        int land;
        bus_write_at(32'h00, 32'h0, 0, land);
        m_en = 0;
        bus_write_at(32'h10, 32'h1, 0, land);
        m_tif_base = 0;
        bus_write_at(32'h08, 32'(v0), 0, land);
        bus_write_at(32'h04, 32'(l), 0, land);
        bus_write_at(32'h0C, 32'(p), 0, land);
        m_v0 = v0; m_load = l; m_p = p; m_os = ctrl[2]; m_ie = ctrl[1];
        bus_write_at(32'h00, {29'b0, ctrl}, 0, land);
        m_en = ctrl[0]; m_e = land; m_clr = land; m_tif_base = 0;
    endtask

    initial begin
        int land, tgt;
        logic [31:0] d;
        HRESETn = 0; HSEL = 0; HADDR = 0; HTRANS = 0; HSIZE = 3'b010; HPROT = 4'b0011;
        HWRITE = 0; HWDATA = 0; HREADY = 1;

        // Reset state and an all-offsets read sweep.
        repeat (3) @(posedge HCLK);
        #1;
        check("rst_irq", {31'b0, IRQ}, 32'h0);
        check("rst_hrdata", HRDATA, 32'h0);
        check("rst_okay", {30'b0, HREADYOUT, HRESP}, 32'h2);
        HRESETn = 1;
        for (int i = 0; i < 8; i++) rd_chk(32'(i * 4), "rst_read");

        // Periodic run: LOAD=3, PRESC=1, EN|IE, VALUE polled by a pipelined read burst.
        setup(3, 1, 0, 3'b011);
        HSEL = 1; HTRANS = 2'b10; HWRITE = 0; HADDR = 32'h08;
        for (int i = 0; i < 20; i++) begin
            @(posedge HCLK);
            @(negedge HCLK);
            check("burst_value", HRDATA, 32'(value_at(cyc)));
            check("burst_irq", {31'b0, IRQ}, {31'b0, tif_at(cyc)});
        end
        HSEL = 0; HTRANS = 2'b00;

        // W1C away from an expiry, then aligned to one.
        tgt = cyc + 4;
        while (expiry_in(tgt, tgt)) tgt++;
        bus_write_at(32'h10, 32'h1, tgt, land);
        model_clear(land);
        @(posedge HCLK); @(negedge HCLK);
        check("w1c_irq", {31'b0, IRQ}, {31'b0, tif_at(cyc)});
        rd_chk(32'h10, "w1c_status");
        tgt = cyc + 4;
        while (!expiry_in(tgt, tgt)) tgt++;
        bus_write_at(32'h10, 32'h1, tgt, land);
        model_clear(land);
        @(posedge HCLK); @(negedge HCLK);
        check("w1c_vs_set_irq", {31'b0, IRQ}, {31'b0, tif_at(cyc)});
        rd_chk(32'h10, "w1c_vs_set_status");

        // One-shot: LOAD=5, PRESC=0, EN|ONESHOT.
        setup(5, 0, 2, 3'b101);
        repeat (30) @(posedge HCLK);
        rd_chk(32'h00, "os_ctrl");
        rd_chk(32'h08, "os_value");
        rd_chk(32'h10, "os_status");
        bus_write_at(32'h10, 32'h1, 0, land);
        model_clear(land);
        repeat (20) @(posedge HCLK);
        rd_chk(32'h10, "os_no_reset");

        // Back-to-back write then read of VALUE with the timer stopped.
        setup(0, 32'hFFFF, 0, 3'b000);
        @(posedge HCLK); #1;
        HSEL = 1; HTRANS = 2'b10; HWRITE = 1; HADDR = 32'h08;
        @(posedge HCLK); #1;
        HWDATA = 32'h1234; HWRITE = 0; HADDR = 32'h08;
        @(posedge HCLK); #1;
        HSEL = 0; HTRANS = 2'b00;
        @(negedge HCLK);
        check("b2b_value", HRDATA, 32'h0000_1234);
        m_v0 = 32'h1234;

        // VALUE writes landing on a plain tick and on an expiry tick.
        setup(7, 3, 5, 3'b011);
        bus_write_at(32'h08, 32'h40, m_e + 8, land);
        model_value_write(land, 32'h40);
        rd_chk(32'h08, "tick_wr_value");
        tgt = cyc + 4;
        while (!expiry_in(tgt, tgt)) tgt++;
        bus_write_at(32'h08, 32'h20, tgt, land);
        model_value_write(land, 32'h20);
        rd_chk(32'h08, "exp_wr_value");
        rd_chk(32'h10, "exp_wr_status");

        // Randomized configurations with interleaved reads and W1C writes.
        for (int it = 0; it < 6; it++) begin
            setup($urandom_range(0, 5), $urandom_range(0, 3), $urandom_range(0, 6),
                  {1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1});
            for (int r = 0; r < 8; r++) begin
                repeat ($urandom_range(0, 6)) @(posedge HCLK);
                case ($urandom_range(0, 3))
                    0: rd_chk(32'h08, "rnd_value");
                    1: rd_chk(32'h10, "rnd_status");
                    2: rd_chk(32'h00, "rnd_ctrl");
                    default: begin
                        d = $urandom;
                        bus_write_at(32'h10, d, 0, land);
                        if (d[0]) model_clear(land);
                    end
                endcase
            end
        end

        // IDLE transfer and unmapped offset writes change nothing.
        @(posedge HCLK); #1;
        HSEL = 1; HTRANS = 2'b00; HWRITE = 1; HADDR = 32'h04;
        @(posedge HCLK); #1;
        HSEL = 0; HWRITE = 0; HWDATA = 32'hDEAD_BEEF;
        rd_chk(32'h04, "idle_load");
        bus_write_at(32'h18, 32'hFFFF_FFFF, 0, land);
        rd_chk(32'h18, "unmapped_read");
        rd_chk(32'h04, "unmapped_load");
        rd_chk(32'h0C, "unmapped_presc");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/ahblite_timer.md
Name: ahblite_timer

Overview:
AHB-Lite slave peripheral that plugs into one peripheral port (P0..P3) of the AHB-Lite interconnect. It provides a memory-mapped, prescaled, down-counting timer with auto-reload or one-shot mode and a sticky interrupt flag. The deskClock firmware uses it as its periodic tick source. Zero-wait-state slave that never returns an error response.

Parameters:
CNT_W, 32, width of LOAD/VALUE (1..32); register bits above CNT_W read 0 and ignore writes
PRESC_W, 16, width of PRESC register and prescaler counter (1..32)

Ports:
HCLK  in  1  clock
HRESETn  in  1  synchronous reset, active-low
HSEL  in  1  slave select from interconnect decoder
HADDR  in  32  address; only HADDR[4:2] decoded
HTRANS  in  2  transfer type; HTRANS[1]=1 means NONSEQ/SEQ
HSIZE  in  3  ignored; all accesses are treated as 32-bit
HPROT  in  4  ignored
HWRITE  in  1  1=write
HWDATA  in  32  write data, data phase
HREADY  in  1  bus-wide ready from interconnect
HREADYOUT  out  1  constant 1
HRDATA  out  32  read data, data phase
HRESP  out  1  constant 0 (OKAY)
IRQ  out  1  TIF & IE

Behaviour:
- Reset: HRESETn=0 sampled on the HCLK rising edge clears all registers, the address-phase latch and the prescaler. After reset, HRDATA=0 and IRQ=0. HREADYOUT=1 and HRESP=0 at all times.
- Register map (word offsets):
  - 0x00 CTRL: [0] EN, [1] IE, [2] ONESHOT.
  - 0x04 LOAD: RW.
  - 0x08 VALUE: RW; a write sets the counter directly.
  - 0x0C PRESC: RW.
  - 0x10 STATUS: [0] TIF; writing 1 clears it (W1C), writing 0 has no effect.
  - Offsets 0x14-0x1C: read 0, writes ignored.
- Address phase: when HSEL & HREADY & HTRANS[1] on an edge, latch wr_pend=HWRITE, rd_pend=~HWRITE and addr=HADDR[4:2]. Otherwise clear wr_pend and rd_pend on that edge. IDLE/BUSY transfers have no effect.
- Write data phase: on the next edge with wr_pend=1, the register selected by the latched addr takes HWDATA. Back-to-back writes are supported with no wait states.
- Read data phase: HRDATA = register selected by the latched addr, driven combinationally from the registers while rd_pend=1. When rd_pend=0, HRDATA=0.
- Read-after-write to the same register in consecutive transfers returns the new value, because the write lands before the read's data phase.
- Prescaler:
  - While EN=1, pcnt increments every cycle.
  - When pcnt==PRESC: pcnt<=0 and tick=1 for that cycle.
  - While EN=0, pcnt is held at 0.
  - Writing PRESC does not reset pcnt. If pcnt>PRESC, pcnt counts up to its maximum and wraps to 0 naturally.
- Counter, on tick:
  - VALUE!=0: VALUE<=VALUE-1.
  - VALUE==0: VALUE<=LOAD and TIF<=1. If ONESHOT=1, EN<=0 as well.
  - Period = (LOAD+1)*(PRESC+1) HCLK cycles.
- Simultaneous events:
  - Bus write to VALUE in the same cycle as a tick: the bus write wins and the tick's decrement/reload is discarded. TIF is still set if the tick was an expiry.
  - TIF set and STATUS W1C in the same cycle: set wins and TIF stays 1.
  - Bus write to CTRL in the same cycle as a one-shot expiry: the bus-written EN wins.
- Enabling: a write setting EN=1 starts pcnt from 0, so the first tick occurs PRESC+1 cycles after the write edge.
- IRQ: combinational AND of the registered TIF and IE; it depends on no bus input. A level interrupt, cleared only by W1C or reset.
- Reset mid-transfer: any pending address phase is discarded and the following cycle behaves as idle.

Test Plan:
1. Reset, then read all 8 offsets -> every read returns 0x00000000; HREADYOUT=1 and HRESP=0 throughout; IRQ=0.
2. Write LOAD=3, PRESC=1, CTRL=0x3 (EN|IE) -> VALUE sequence after enable 0,3,2,1,0,3,… changing every 2 cycles. TIF/IRQ rise on the first wrap (2 cycles after enable), then every 8 cycles.
3. Set TIF, write STATUS=0x1 -> TIF=0 and IRQ=0 next cycle. Repeat with the W1C aligned to an expiry tick -> TIF stays 1.
4. One-shot: LOAD=5, PRESC=0, CTRL=0x5 -> after the expiry EN reads 0, VALUE holds 5, TIF=1, and no further TIF sets.
5. Back-to-back write VALUE=0x1234 then read VALUE with PRESC=0xFFFF -> read returns 0x00001234. Write VALUE on a tick cycle -> the written value is kept, with no decrement.
6. IDLE transfer (HTRANS=00) with HSEL=1 and HWRITE=1 to LOAD -> LOAD unchanged. Write to offset 0x18 -> no register changes and reads return 0.
